// File: rtl/mesh_term_fifo_array_if.sv
// Host/mesh handshake bundle for mesh_term_fifo_array.
// The MESH_TERM_STATS_EN macro adds the per-terminal packet counters.
interface mesh_term_fifo_array_if #(
    parameter int ROWS    = 4,
    parameter int COLUMNS = 4,
    parameter int pkg_sz  = 40
);
    localparam int NTERM = 2 * ROWS + 2 * COLUMNS;

    logic [NTERM-1:0]        inj_wr;
    logic [NTERM*pkg_sz-1:0] inj_data;
    logic [NTERM-1:0]        inj_full;
    logic [NTERM-1:0]        pndng_i_in;
    logic [NTERM*pkg_sz-1:0] data_out_i_in;
    logic [NTERM-1:0]        popin;
    logic [NTERM-1:0]        pndng;
    logic [NTERM*pkg_sz-1:0] data_out;
    logic [NTERM-1:0]        pop;
    logic [NTERM-1:0]        rx_rd;
    logic [NTERM*pkg_sz-1:0] rx_data;
    logic [NTERM-1:0]        rx_empty;
    logic [NTERM-1:0]        err_ovf;
    logic [NTERM-1:0]        err_udf;
`ifdef MESH_TERM_STATS_EN
    logic [NTERM*16-1:0]     inj_cnt;
    logic [NTERM*16-1:0]     rx_cnt;
`endif

    modport slave (
`ifdef MESH_TERM_STATS_EN
        output inj_cnt,
        output rx_cnt,
`endif
        input  inj_wr,
        input  inj_data,
        output inj_full,
        output pndng_i_in,
        output data_out_i_in,
        input  popin,
        input  pndng,
        input  data_out,
        output pop,
        input  rx_rd,
        output rx_data,
        output rx_empty,
        output err_ovf,
        output err_udf
    );

    modport master (
`ifdef MESH_TERM_STATS_EN
        input  inj_cnt,
        input  rx_cnt,
`endif
        output inj_wr,
        output inj_data,
        input  inj_full,
        input  pndng_i_in,
        input  data_out_i_in,
        output popin,
        output pndng,
        output data_out,
        input  pop,
        output rx_rd,
        input  rx_data,
        input  rx_empty,
        input  err_ovf,
        input  err_udf
    );
endinterface

// File: rtl/mesh_term_fifo_array.sv
// Per-terminal injection and receive FIFOs between host and mesh edge terminals.
// Optional MESH_TERM_STATS_EN adds saturating accepted/captured packet counters.
module mesh_term_fifo_array #(
    parameter int ROWS       = 4,
    parameter int COLUMNS    = 4,
    parameter int pkg_sz     = 40,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mesh_term_fifo_array_if.slave bus
);
    localparam int NTERM = 2 * ROWS + 2 * COLUMNS;
    localparam int PW    = $clog2(fifo_depth);
    localparam int CW    = PW + 1;

    for (genvar t = 0; t < NTERM; t++) begin : g_term
        logic [pkg_sz-1:0] inj_mem_q [fifo_depth];
        logic [pkg_sz-1:0] rx_mem_q  [fifo_depth];
        logic [PW-1:0]     inj_wp_q, inj_wp_d, inj_rp_q, inj_rp_d;
        logic [PW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
        logic [CW-1:0]     inj_cnt_q, inj_cnt_d, rx_cnt_q, rx_cnt_d;
        logic              ovf_q, ovf_d, udf_q, udf_d;
        logic              inj_full_s, inj_empty_s, inj_push_s, inj_pop_s;
        logic              rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;

        assign inj_full_s  = (inj_cnt_q == CW'(fifo_depth));
        assign inj_empty_s = (inj_cnt_q == {CW{1'b0}});
        // A full FIFO still accepts a write when the head retires on the same edge.
        assign inj_push_s  = bus.inj_wr[t] && (!inj_full_s || bus.popin[t]);
        assign inj_pop_s   = bus.popin[t] && !inj_empty_s;

        assign rx_full_s   = (rx_cnt_q == CW'(fifo_depth));
        assign rx_empty_s  = (rx_cnt_q == {CW{1'b0}});
        assign rx_push_s   = bus.pndng[t] && !rx_full_s && !reset;
        assign rx_pop_s    = bus.rx_rd[t] && !rx_empty_s;

        // Next-state for pointers, counts and sticky error flags.
        always_comb begin
            inj_wp_d  = inj_wp_q;
            inj_rp_d  = inj_rp_q;
            inj_cnt_d = inj_cnt_q;
            rx_wp_d   = rx_wp_q;
            rx_rp_d   = rx_rp_q;
            rx_cnt_d  = rx_cnt_q;
            if (inj_push_s) begin
                inj_wp_d = inj_wp_q + PW'(1);
            end else begin
                inj_wp_d = inj_wp_q;
            end
            if (inj_pop_s) begin
                inj_rp_d = inj_rp_q + PW'(1);
            end else begin
                inj_rp_d = inj_rp_q;
            end
            case ({inj_push_s, inj_pop_s})
                2'b10:   inj_cnt_d = inj_cnt_q + CW'(1);
                2'b01:   inj_cnt_d = inj_cnt_q - CW'(1);
                default: inj_cnt_d = inj_cnt_q;
            endcase
            if (rx_push_s) begin
                rx_wp_d = rx_wp_q + PW'(1);
            end else begin
                rx_wp_d = rx_wp_q;
            end
            if (rx_pop_s) begin
                rx_rp_d = rx_rp_q + PW'(1);
            end else begin
                rx_rp_d = rx_rp_q;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
            ovf_d = ovf_q | (bus.inj_wr[t] & ~inj_push_s);
            udf_d = udf_q | (bus.popin[t] & inj_empty_s) | (bus.rx_rd[t] & rx_empty_s);
        end

        // Control state register with synchronous reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                inj_wp_q  <= {PW{1'b0}};
                inj_rp_q  <= {PW{1'b0}};
                inj_cnt_q <= {CW{1'b0}};
                rx_wp_q   <= {PW{1'b0}};
                rx_rp_q   <= {PW{1'b0}};
                rx_cnt_q  <= {CW{1'b0}};
                ovf_q     <= 1'b0;
                udf_q     <= 1'b0;
            end else begin
                inj_wp_q  <= inj_wp_d;
                inj_rp_q  <= inj_rp_d;
                inj_cnt_q <= inj_cnt_d;
                rx_wp_q   <= rx_wp_d;
                rx_rp_q   <= rx_rp_d;
                rx_cnt_q  <= rx_cnt_d;
                ovf_q     <= ovf_d;
                udf_q     <= udf_d;
            end
        end

        // Storage needs no reset: contents are only visible while the count is non-zero.
        always_ff @(posedge clk) begin
            if (inj_push_s) begin
                inj_mem_q[inj_wp_q] <= bus.inj_data[t*pkg_sz +: pkg_sz];
            end
            if (rx_push_s) begin
                rx_mem_q[rx_wp_q] <= bus.data_out[t*pkg_sz +: pkg_sz];
            end
        end

        assign bus.inj_full[t]                        = inj_full_s;
        assign bus.pndng_i_in[t]                      = !inj_empty_s;
        assign bus.data_out_i_in[t*pkg_sz +: pkg_sz]  = inj_empty_s ? {pkg_sz{1'b0}} : inj_mem_q[inj_rp_q];
        assign bus.pop[t]                             = rx_push_s;
        assign bus.rx_empty[t]                        = rx_empty_s;
        assign bus.rx_data[t*pkg_sz +: pkg_sz]        = rx_empty_s ? {pkg_sz{1'b0}} : rx_mem_q[rx_rp_q];
        assign bus.err_ovf[t]                         = ovf_q;
        assign bus.err_udf[t]                         = udf_q;

`ifdef MESH_TERM_STATS_EN
        logic [15:0] st_inj_q, st_rx_q;

        // Saturating packet counters.
        always_ff @(posedge clk) begin
            if (reset) begin
                st_inj_q <= 16'h0000;
                st_rx_q  <= 16'h0000;
            end else begin
                if (inj_pop_s && (st_inj_q != 16'hFFFF)) begin
                    st_inj_q <= st_inj_q + 16'h0001;
                end
                if (rx_push_s && (st_rx_q != 16'hFFFF)) begin
                    st_rx_q <= st_rx_q + 16'h0001;
                end
            end
        end

        assign bus.inj_cnt[t*16 +: 16] = st_inj_q;
        assign bus.rx_cnt[t*16 +: 16]  = st_rx_q;
`endif
    end
endmodule

// File: tb/tb_mesh_term_fifo_array.sv
// Directed and randomized bench for mesh_term_fifo_array against a queue-based model.
module tb_mesh_term_fifo_array;
    localparam int ROWS    = 4;
    localparam int COLUMNS = 4;
    localparam int PKG     = 40;
    localparam int DEPTH   = 4;
    localparam int NTERM   = 2 * ROWS + 2 * COLUMNS;
    localparam int W       = NTERM * PKG;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mesh_term_fifo_array_if #(.ROWS(ROWS), .COLUMNS(COLUMNS), .pkg_sz(PKG)) bus ();

    mesh_term_fifo_array #(
        .ROWS(ROWS), .COLUMNS(COLUMNS), .pkg_sz(PKG), .fifo_depth(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [PKG-1:0] inj_q [NTERM][$];
    logic [PKG-1:0] rx_q  [NTERM][$];
    bit             ovf_m [NTERM];
    bit             udf_m [NTERM];
    int             inj_acc [NTERM];
    int             rx_acc  [NTERM];
    int             n_assert = 0;
    int             n_fail   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.inj_wr   = '0;
        bus.inj_data = '0;
        bus.popin    = '0;
        bus.pndng    = '0;
        bus.data_out = '0;
        bus.rx_rd    = '0;
    endtask

    task automatic set_inj(input int t, input logic [PKG-1:0] d);
        bus.inj_data[t*PKG +: PKG] = d;
    endtask

    task automatic set_dout(input int t, input logic [PKG-1:0] d);
        bus.data_out[t*PKG +: PKG] = d;
    endtask

    // Model: apply one clock edge using the inputs present at that edge.
    task automatic model_step();
        for (int t = 0; t < NTERM; t++) begin
            if (reset) begin
                inj_q[t].delete();
                rx_q[t].delete();
                ovf_m[t]   = 1'b0;
                udf_m[t]   = 1'b0;
                inj_acc[t] = 0;
                rx_acc[t]  = 0;
            end else begin
                int isz = inj_q[t].size();
                int rsz = rx_q[t].size();
                bit acc = bus.inj_wr[t] && ((isz < DEPTH) || bus.popin[t]);
                bit cap = bus.pndng[t] && (rsz < DEPTH);
                if (bus.popin[t]) begin
                    if (isz > 0) begin
                        void'(inj_q[t].pop_front());
                        if (inj_acc[t] < 65535) inj_acc[t]++;
                    end else begin
                        udf_m[t] = 1'b1;
                    end
                end
                if (bus.inj_wr[t] && !acc) ovf_m[t] = 1'b1;
                if (acc) inj_q[t].push_back(bus.inj_data[t*PKG +: PKG]);
                if (bus.rx_rd[t]) begin
                    if (rsz > 0) void'(rx_q[t].pop_front());
                    else udf_m[t] = 1'b1;
                end
                if (cap) begin
                    rx_q[t].push_back(bus.data_out[t*PKG +: PKG]);
                    if (rx_acc[t] < 65535) rx_acc[t]++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [W-1:0]     e_head, e_rx;
        logic [NTERM-1:0] e_pnd, e_full, e_empty, e_pop, e_ovf, e_udf;
`ifdef MESH_TERM_STATS_EN
        logic [NTERM*16-1:0] e_ic, e_rc;
`endif
        for (int t = 0; t < NTERM; t++) begin
            e_pnd[t]             = (inj_q[t].size() != 0);
            e_head[t*PKG +: PKG] = (inj_q[t].size() != 0) ? inj_q[t][0] : '0;
            e_full[t]            = (inj_q[t].size() == DEPTH);
            e_empty[t]           = (rx_q[t].size() == 0);
            e_rx[t*PKG +: PKG]   = (rx_q[t].size() != 0) ? rx_q[t][0] : '0;
            e_pop[t]             = bus.pndng[t] && (rx_q[t].size() < DEPTH) && !reset;
            e_ovf[t]             = ovf_m[t];
            e_udf[t]             = udf_m[t];
`ifdef MESH_TERM_STATS_EN
            e_ic[t*16 +: 16]     = inj_acc[t][15:0];
            e_rc[t*16 +: 16]     = rx_acc[t][15:0];
`endif
        end
        chk("pndng_i_in", W'(bus.pndng_i_in), W'(e_pnd));
        chk("data_out_i_in", bus.data_out_i_in, e_head);
        chk("inj_full", W'(bus.inj_full), W'(e_full));
        chk("rx_empty", W'(bus.rx_empty), W'(e_empty));
        chk("rx_data", bus.rx_data, e_rx);
        chk("pop", W'(bus.pop), W'(e_pop));
        chk("err_ovf", W'(bus.err_ovf), W'(e_ovf));
        chk("err_udf", W'(bus.err_udf), W'(e_udf));
`ifdef MESH_TERM_STATS_EN
        chk("inj_cnt", W'(bus.inj_cnt), W'(e_ic));
        chk("rx_cnt", W'(bus.rx_cnt), W'(e_rc));
`endif
    endtask

    // One clock: check pre-edge outputs, take the edge, advance the model.
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int npop;
        logic [63:0] r;

        reset = 1'b1;
        clear_inputs();
        repeat (2) begin
            @(posedge clk);
            model_step();
        end
        #1;
        cycle();
        reset = 1'b0;
        repeat (5) cycle();
        chk("idle_rx_empty", W'(bus.rx_empty), W'({NTERM{1'b1}}));

        // T0: two writes then two pops.
        bus.inj_wr[0] = 1'b1;
        set_inj(0, 40'hA1);
        cycle();
        set_inj(0, 40'hA2);
        cycle();
        bus.inj_wr[0] = 1'b0;
        chk("t0_head_a1", W'(bus.data_out_i_in[PKG-1:0]), W'(40'hA1));
        bus.popin[0] = 1'b1;
        cycle();
        chk("t0_head_a2", W'(bus.data_out_i_in[PKG-1:0]), W'(40'hA2));
        cycle();
        bus.popin[0] = 1'b0;
        chk("t0_pndng_low", W'(bus.pndng_i_in[0]), W'(1'b0));

        // T3: five writes into depth four, then drain.
        bus.inj_wr[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_inj(3, 40'h30 + 40'(k));
            cycle();
            if (k == 3) chk("t3_full_after_4", W'(bus.inj_full[3]), W'(1'b1));
        end
        bus.inj_wr[3] = 1'b0;
        chk("t3_ovf", W'(bus.err_ovf[3]), W'(1'b1));
        bus.popin[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_drain", W'(bus.data_out_i_in[3*PKG +: PKG]), W'(40'h30 + 40'(k)));
            cycle();
        end
        bus.popin[3] = 1'b0;
        chk("t3_empty", W'(bus.pndng_i_in[3]), W'(1'b0));

        // T7: mesh output held pending, receive FIFO fills and throttles pop.
        bus.pndng[7] = 1'b1;
        set_dout(7, 40'h77);
        npop = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (bus.pop[7]) npop++;
            cycle();
        end
        chk("t7_pop_count", W'(npop), W'(4));
        bus.rx_rd[7] = 1'b1;
        cycle();
        bus.rx_rd[7] = 1'b0;
        #1;
        chk("t7_pop_resume", W'(bus.pop[7]), W'(1'b1));
        cycle();
        #1;
        chk("t7_pop_stop", W'(bus.pop[7]), W'(1'b0));
        bus.pndng[7] = 1'b0;
        bus.rx_rd[7] = 1'b1;
        repeat (5) cycle();
        bus.rx_rd[7] = 1'b0;
        chk("t7_udf", W'(bus.err_udf[7]), W'(1'b1));

        // T5: simultaneous write and pop at full.
        bus.inj_wr[5] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_inj(5, 40'h50 + 40'(k));
            cycle();
        end
        set_inj(5, 40'h54);
        bus.popin[5] = 1'b1;
        cycle();
        bus.inj_wr[5] = 1'b0;
        chk("t5_still_full", W'(bus.inj_full[5]), W'(1'b1));
        chk("t5_no_ovf", W'(bus.err_ovf[5]), W'(1'b0));
        for (int k = 1; k < 5; k++) begin
            chk("t5_drain", W'(bus.data_out_i_in[5*PKG +: PKG]), W'(40'h50 + 40'(k)));
            cycle();
        end
        bus.popin[5] = 1'b0;

        // T1: reset with buffered packets and mesh pending.
        bus.inj_wr[1] = 1'b1;
        set_inj(1, 40'h11);
        cycle();
        set_inj(1, 40'h12);
        cycle();
        bus.inj_wr[1] = 1'b0;
        bus.pndng[1] = 1'b1;
        set_dout(1, 40'h1F);
        cycle();
        reset = 1'b1;
        #1;
        chk("t1_pop_in_reset", W'(bus.pop[1]), W'(1'b0));
        cycle();
        reset = 1'b0;
        clear_inputs();
        cycle();
        chk("t1_inj_empty", W'(bus.pndng_i_in), W'(0));
        chk("t1_rx_empty", W'(bus.rx_empty), W'({NTERM{1'b1}}));
        chk("t1_err_clr", W'({bus.err_ovf, bus.err_udf}), W'(0));

        // Randomized traffic on all terminals, occasional reset.
        for (int n = 0; n < 400; n++) begin
            for (int t = 0; t < NTERM; t++) begin
                bus.inj_wr[t] = 1'($urandom_range(0, 1));
                bus.popin[t]  = 1'($urandom_range(0, 1));
                bus.pndng[t]  = ($urandom_range(0, 3) != 0);
                bus.rx_rd[t]  = 1'($urandom_range(0, 1));
                r = {$urandom, $urandom};
                set_inj(t, r[PKG-1:0]);
                r = {$urandom, $urandom};
                set_dout(t, r[PKG-1:0]);
            end
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        clear_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
